// File: rtl/fc_cif_acc_relu.sv
// fc_cif_acc_relu: accumulates a neuron's product stream, adds bias, rescales, saturates to 32 bits
// and applies optional ReLU, with valid/ready handshakes on both sides.
module fc_cif_acc_relu #(
    parameter int ACC_W      = 48,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU_EN    = 1,
    parameter int MAX_LEN    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prod_valid,
    input  logic [31:0] prod_data,
    input  logic        prod_last,
    output logic        prod_ready,
    input  logic [31:0] bias_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        sat_flag,
    output logic        len_err
);
    typedef enum logic [1:0] {ACC, BIAS, SAT, OUT} state_t;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic signed [ACC_W-1:0] POS_MAX = {{(ACC_W-32){1'b0}}, 32'h7fff_ffff};
    localparam logic signed [ACC_W-1:0] NEG_MIN = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

    state_t state, state_nx;
    logic signed [ACC_W-1:0] acc, shifted;
    logic [31:0] bias, sat_val, relu_val;
    logic [CNT_W-1:0] beat_cnt;
    logic take, at_max, end_vec, over, under;

    assign take     = prod_valid && prod_ready;
    assign at_max   = beat_cnt == CNT_W'(MAX_LEN - 1);
    assign end_vec  = take && (prod_last || at_max);
    assign shifted  = acc >>> FRAC_SHIFT;
    assign over     = shifted > POS_MAX;
    assign under    = shifted < NEG_MIN;
    assign sat_val  = over ? 32'h7fff_ffff : under ? 32'h8000_0000 : shifted[31:0];
    assign relu_val = (RELU_EN != 0 && sat_val[31]) ? 32'h0 : sat_val;

    always_comb begin
        state_nx = state;
        case (state)
            ACC:  state_nx = end_vec ? BIAS : ACC;
            BIAS: state_nx = SAT;
            SAT:  state_nx = OUT;
            OUT:  state_nx = res_ready ? ACC : OUT;
            default: state_nx = ACC;
        endcase
    end

    // handshake outputs are registered from the next state so they depend only on state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACC;
            acc        <= '0;
            beat_cnt   <= '0;
            bias       <= '0;
            prod_ready <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= '0;
            sat_flag   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            prod_ready <= state_nx == ACC;
            res_valid  <= state_nx == OUT;
            case (state)
                ACC: if (take) begin
                    acc      <= acc + {{(ACC_W-32){prod_data[31]}}, prod_data};
                    beat_cnt <= beat_cnt + 1'b1;
                    if (end_vec) bias <= bias_data;
                    if (at_max && !prod_last) len_err <= 1'b1;
                end
                BIAS: begin
                    acc      <= acc + {{(ACC_W-32){bias[31]}}, bias};
                    beat_cnt <= '0;
                end
                SAT: begin
                    res_data <= relu_val;
                    sat_flag <= over || under;
                    acc      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_cif_acc_relu.sv
// tb_fc_cif_acc_relu: four parameter variants of fc_cif_acc_relu driven in lockstep,
// results checked against a reference model through per-instance scoreboards.
module tb_fc_cif_acc_relu;
    logic        clk = 1'b0;
    logic        reset;
    logic        pv [4];
    logic [31:0] prod_data;
    logic        prod_last;
    logic [31:0] bias_data;
    logic        res_ready;
    logic        pr [4], rv [4], sf [4], le [4];
    logic [31:0] rd [4];

    int sh_p [4] = '{0, 0, 8, 0};
    bit rl_p [4] = '{1, 0, 0, 1};
    logic [32:0] exp_q [4][$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fc_cif_acc_relu #(.ACC_W(48), .FRAC_SHIFT(0), .RELU_EN(1), .MAX_LEN(1024)) d0 (
        .clk(clk), .reset(reset), .prod_valid(pv[0]), .prod_data(prod_data), .prod_last(prod_last),
        .prod_ready(pr[0]), .bias_data(bias_data), .res_valid(rv[0]), .res_ready(res_ready),
        .res_data(rd[0]), .sat_flag(sf[0]), .len_err(le[0]));
    fc_cif_acc_relu #(.ACC_W(48), .FRAC_SHIFT(0), .RELU_EN(0), .MAX_LEN(1024)) d1 (
        .clk(clk), .reset(reset), .prod_valid(pv[1]), .prod_data(prod_data), .prod_last(prod_last),
        .prod_ready(pr[1]), .bias_data(bias_data), .res_valid(rv[1]), .res_ready(res_ready),
        .res_data(rd[1]), .sat_flag(sf[1]), .len_err(le[1]));
    fc_cif_acc_relu #(.ACC_W(48), .FRAC_SHIFT(8), .RELU_EN(0), .MAX_LEN(1024)) d2 (
        .clk(clk), .reset(reset), .prod_valid(pv[2]), .prod_data(prod_data), .prod_last(prod_last),
        .prod_ready(pr[2]), .bias_data(bias_data), .res_valid(rv[2]), .res_ready(res_ready),
        .res_data(rd[2]), .sat_flag(sf[2]), .len_err(le[2]));
    fc_cif_acc_relu #(.ACC_W(48), .FRAC_SHIFT(0), .RELU_EN(1), .MAX_LEN(4)) d3 (
        .clk(clk), .reset(reset), .prod_valid(pv[3]), .prod_data(prod_data), .prod_last(prod_last),
        .prod_ready(pr[3]), .bias_data(bias_data), .res_valid(rv[3]), .res_ready(res_ready),
        .res_data(rd[3]), .sat_flag(sf[3]), .len_err(le[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // {sat_flag, res_data} for a full-precision sum
    function automatic logic [32:0] model(input longint s, input int sh, input bit relu);
        longint t;
        logic [31:0] d;
        logic sat;
        t = s >>> sh;
        sat = 1'b1;
        if (t > 64'sd2147483647) d = 32'h7fff_ffff;
        else if (t < -64'sd2147483648) d = 32'h8000_0000;
        else begin
            d = t[31:0];
            sat = 1'b0;
        end
        if (relu && d[31]) d = 32'h0;
        return {sat, d};
    endfunction

    task automatic send(input logic [3:0] mask, input int n, input int b [8], input bit lastf,
                        input int bias, input bit push);
        longint s = 0;
        int idx = 0;
        int w;
        for (int k = 3; k >= 0; k--) if (mask[k]) idx = k;
        bias_data = bias;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) pv[k] = mask[k];
            prod_data = b[i];
            prod_last = lastf && (i == n - 1);
            w = 0;
            while (!pr[idx] && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            chk("ready_timeout", 64'(w < 50), 64'd1);
            @(posedge clk); #1;
            s += longint'(b[i]);
        end
        for (int k = 0; k < 4; k++) pv[k] = 1'b0;
        prod_last = 1'b0;
        if (push)
            for (int k = 0; k < 4; k++)
                if (mask[k]) exp_q[k].push_back(model(s + longint'(bias), sh_p[k], rl_p[k]));
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < 4; k++)
            chk($sformatf("reset_state%0d", k), 64'({pr[k], rv[k], sf[k], le[k], rd[k]}),
                64'({1'b1, 3'b000, 32'h0}));
    endtask

    always @(negedge clk)
        if (!reset)
            for (int k = 0; k < 4; k++)
                if (rv[k] && res_ready) begin
                    chk($sformatf("sb_nonempty%0d", k), 64'(exp_q[k].size() != 0), 64'd1);
                    if (exp_q[k].size() != 0)
                        chk($sformatf("result%0d", k), 64'({sf[k], rd[k]}), 64'(exp_q[k].pop_front()));
                end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) pv[k] = 1'b0;
        prod_data = '0;
        prod_last = 1'b0;
        bias_data = '0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk_reset_state();
        reset = 1'b0;
        settle(1);

        // basic accumulate + bias, and the three-cycle result latency
        send(4'hf, 4, '{10, 20, -5, 3, 0, 0, 0, 0}, 1, 100, 1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rv[0] && c < 20);
        chk("latency", 64'(c), 64'd3);
        settle(4);

        send(4'hf, 1, '{-50, 0, 0, 0, 0, 0, 0, 0}, 1, 10, 1);
        settle(6);
        send(4'hf, 2, '{32'sh7fffffff, 32'sh7fffffff, 0, 0, 0, 0, 0, 0}, 1, 0, 1);
        settle(6);
        send(4'hf, 2, '{32'sh80000000, 32'sh80000000, 0, 0, 0, 0, 0, 0}, 1, 0, 1);
        settle(6);
        send(4'hf, 2, '{-256, -1, 0, 0, 0, 0, 0, 0}, 1, 0, 1);
        settle(6);

        // backpressure in OUT
        res_ready = 1'b0;
        send(4'hf, 2, '{7, 8, 0, 0, 0, 0, 0, 0}, 1, 5, 1);
        c = 0;
        while (!rv[0] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("out_reached", 64'(c < 20), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rv[0]), 64'd1);
            chk("hold_data", 64'(rd[0]), 64'd20);
            chk("hold_ready", 64'(pr[0]), 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_ready", 64'(pr[0]), 64'd1);
        chk("post_hs_valid", 64'(rv[0]), 64'd0);
        #1;
        send(4'hf, 1, '{4, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 1);
        settle(6);
        chk("len_err_clean", 64'(le[3]), 64'd0);

        // forced termination at MAX_LEN, then reset mid-vector
        send(4'h8, 4, '{1, 1, 1, 1, 0, 0, 0, 0}, 0, 5, 1);
        settle(6);
        chk("len_err_set", 64'(le[3]), 64'd1);
        chk("len_err_other", 64'(le[0]), 64'd0);
        send(4'h8, 2, '{9, 9, 0, 0, 0, 0, 0, 0}, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk_reset_state();
        @(posedge clk); #1;
        reset = 1'b0;
        settle(1);
        send(4'h8, 2, '{1, 2, 0, 0, 0, 0, 0, 0}, 1, 0, 1);
        settle(6);

        for (int k = 0; k < 4; k++)
            chk($sformatf("sb_drained%0d", k), 64'(exp_q[k].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
